// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//
// Contents:
//   WORD_BYTES - bytes per imem word (stream is assembled little-endian)
//   state_t    - loader FSM state encoding; StTrl exists only when
//                IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef logic [2:0] state_t;

    localparam state_t StHdr   = 3'd0;
    localparam state_t StData  = 3'd1;
    localparam state_t StWrite = 3'd2;
    localparam state_t StDone  = 3'd3;
    localparam state_t StErr   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t StTrl   = 3'd5;
`endif

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-to-word assembler for the imem loader.
//
// Byte k of a word lands in bits [8k+7:8k]. word_o is the word including the
// byte being accepted this cycle, so the FSM can act on a complete word in
// the same cycle its last byte arrives.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   accept_i      - a stream byte is transferred this cycle
//   clear_i       - discard any partial word and restart at byte 0
//   byte_i        - stream byte
//   word_o        - assembled word (valid when word_ready_o is high)
//   word_ready_o  - the last byte of a word is accepted this cycle
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [1:0] LastIdx = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    always_comb begin
        word_o = word_q;
        if (accept_i) begin
            word_o[{idx_q, 3'b000} +: 8] = byte_i;
        end
        word_ready_o = accept_i && (idx_q == LastIdx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear_i) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (accept_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
//
// Accepts a byte stream (4-byte little-endian word count N, then N words LSB
// first), writes each word to imem at BASE_ADDR + 4*index and holds the CPU in
// reset until the whole image has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a 4-byte trailer
// after the data words holding the mod-2^32 sum of all data words; a matching
// trailer finishes the load, a mismatch rejects it.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   byte_valid_i, byte_i  - stream byte from the source
//   byte_ready_o          - loader accepts a byte this cycle
//   imem_we_o             - one-cycle imem write strobe
//   imem_waddr_o          - word-aligned byte address
//   imem_wdata_o          - write data
//   cpu_rst_n_o           - active-low CPU reset, released when load is done
//   load_done_o           - image loaded (sticky)
//   load_err_o            - image rejected (sticky)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_waddr_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_rst_n_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] n_q, n_d;
    logic        ready_q, we_q, done_q, err_q;
    logic [31:0] waddr_q, wdata_q;

    logic        accept, clear, word_ready;
    logic [31:0] word;

    assign accept = byte_valid_i && ready_q;
    // Leftover partial bytes never matter once the load has terminated.
    assign clear  = (state_q == StDone) || (state_q == StErr);

    imem_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .accept_i     (accept),
        .clear_i      (clear),
        .byte_i       (byte_i),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    localparam state_t StEnd = StTrl;
`else
    localparam state_t StEnd = StDone;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        unique case (state_q)
            StHdr: begin
                if (word_ready) begin
                    n_d = word;
                    if (word == 32'd0) begin
                        state_d = StEnd;
                    end else if (word > IMEM_DEPTH) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                        cnt_d   = 32'd0;
                    end
                end
            end
            StData: begin
                if (word_ready) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                cnt_d   = cnt_q + 32'd1;
                state_d = (cnt_q + 32'd1 == n_q) ? StEnd : StData;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StTrl: begin
                if (word_ready) begin
                    state_d = (word == sum_q) ? StDone : StErr;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // All outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHdr;
            cnt_q   <= 32'd0;
            n_q     <= 32'd0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 32'd0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ready_q <= (state_d == StHdr) || (state_d == StData) || (state_d == StTrl);
`else
            ready_q <= (state_d == StHdr) || (state_d == StData);
`endif
            we_q    <= (state_d == StWrite);
            if (state_d == StWrite) begin
                waddr_q <= BASE_ADDR + {cnt_q[29:0], 2'b00};
                wdata_q <= word;
            end
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StErr);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 32'd0;
        end else if (state_d == StWrite) begin
            sum_q <= sum_q + word;
        end
    end
`endif

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_waddr_o = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_rst_n_o  = done_q;
    assign load_done_o  = done_q;
    assign load_err_o   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_ready_o, imem_we_o, cpu_rst_n_o, load_done_o, load_err_o;
    logic [31:0] imem_waddr_o, imem_wdata_o;

    imem_loader #(
        .IMEM_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_waddr_o (imem_waddr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_rst_n_o  (cpu_rst_n_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] run_sum;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Scoreboard: every imem write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we_o) begin
            check_eq("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
            if (exp_addr.size() == 0) begin
                check_eq("write_when_none_expected", {31'd0, imem_we_o}, 32'd0);
            end else begin
                check_eq("write_addr", imem_waddr_o, exp_addr.pop_front());
                check_eq("write_data", imem_wdata_o, exp_data.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i       = b;
        t = 0;
        while (!byte_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready_o) check_eq("byte_accept_timeout", {31'd0, byte_ready_o}, 32'd1);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * k);
            send_byte(tmp[7:0], gaps);
        end
    endtask

    task automatic send_data(input logic [31:0] w, input int idx, input bit gaps);
        exp_addr.push_back(BASE + 32'(4 * idx));
        exp_data.push_back(w);
        run_sum = run_sum + w;
        send_word(w, gaps);
    endtask

    // Completes a load after the last data word and checks the DONE outputs.
    task automatic finish_load(input bit gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(run_sum, gaps);
`else
        @(negedge clk);
`endif
        check_eq("done", {31'd0, load_done_o}, 32'd1);
        check_eq("cpu_rst_released", {31'd0, cpu_rst_n_o}, 32'd1);
        check_eq("ready_low_in_done", {31'd0, byte_ready_o}, 32'd0);
        check_eq("no_err", {31'd0, load_err_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, imem_we_o}, 32'd0);
        check_eq({tag, "_waddr"}, imem_waddr_o, 32'd0);
        check_eq({tag, "_wdata"}, imem_wdata_o, 32'd0);
        check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n_o}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, load_done_o}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, load_err_o}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        byte_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        exp_addr.delete();
        exp_data.delete();
        run_sum = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", {31'd0, byte_ready_o}, 32'd1);
    endtask

    task automatic check_sb_empty(input string tag);
        check_eq(tag, exp_addr.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        run_sum = 32'd0;
        // Initial reset: outputs zero while rst_n low.
        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_init", {31'd0, byte_ready_o}, 32'd1);

        // N=2 back-to-back.
        send_word(32'd2, 1'b0);
        send_data(32'h0000_0013, 0, 1'b0);
        check_eq("we_after_4th_byte_w0", {31'd0, imem_we_o}, 32'd1);
        send_data(32'hDEAD_BEEF, 1, 1'b0);
        check_eq("we_after_4th_byte_w1", {31'd0, imem_we_o}, 32'd1);
        check_eq("done_not_early", {31'd0, load_done_o}, 32'd0);
        finish_load(1'b0);
        // Bytes offered in DONE must be ignored.
        byte_valid_i = 1'b1;
        byte_i       = 8'hA5;
        repeat (4) @(negedge clk);
        check_eq("ready_stays_low_done", {31'd0, byte_ready_o}, 32'd0);
        check_eq("done_sticky", {31'd0, load_done_o}, 32'd1);
        byte_valid_i = 1'b0;
        check_sb_empty("sb_empty_n2");

        // N=0.
        apply_reset();
        send_word(32'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("n0_waits_trailer", {31'd0, load_done_o}, 32'd0);
        send_word(32'd0, 1'b0);
        check_eq("n0_trl0_done", {31'd0, load_done_o}, 32'd1);
        apply_reset();
        send_word(32'd0, 1'b0);
        send_word(32'd1, 1'b0);
        check_eq("n0_trl1_err", {31'd0, load_err_o}, 32'd1);
        check_eq("n0_trl1_no_done", {31'd0, load_done_o}, 32'd0);
`else
        check_eq("n0_done", {31'd0, load_done_o}, 32'd1);
        check_eq("n0_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd1);
        check_eq("n0_ready", {31'd0, byte_ready_o}, 32'd0);
`endif

        // N=DEPTH+1 is rejected.
        apply_reset();
        send_word(DEPTH + 1, 1'b0);
        check_eq("big_err", {31'd0, load_err_o}, 32'd1);
        check_eq("big_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
        check_eq("big_ready", {31'd0, byte_ready_o}, 32'd0);
        check_eq("big_no_done", {31'd0, load_done_o}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("big_err_sticky", {31'd0, load_err_o}, 32'd1);

        // N=3 with random source gaps.
        apply_reset();
        send_word(32'd3, 1'b1);
        for (int i = 0; i < 3; i++) send_data($urandom, i, 1'b1);
        finish_load(1'b1);
        check_sb_empty("sb_empty_gaps");

        // Reset in the middle of word 1.
        apply_reset();
        send_word(32'd2, 1'b0);
        send_data(32'h1122_3344, 0, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        check_sb_empty("sb_empty_before_abort");
        apply_reset();
        send_word(32'd1, 1'b0);
        send_data(32'hCAFE_F00D, 0, 1'b0);
        finish_load(1'b0);
        check_sb_empty("sb_empty_after_abort");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum wraps modulo 2^32: good and bad trailers.
        apply_reset();
        send_word(32'd2, 1'b0);
        send_data(32'hFFFF_FFFF, 0, 1'b0);
        send_data(32'h0000_0002, 1, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        check_eq("cks_good_done", {31'd0, load_done_o}, 32'd1);
        check_sb_empty("sb_empty_cks_good");
        apply_reset();
        send_word(32'd2, 1'b0);
        send_data(32'hFFFF_FFFF, 0, 1'b0);
        send_data(32'h0000_0002, 1, 1'b0);
        send_word(32'h0000_0002, 1'b0);
        check_eq("cks_bad_err", {31'd0, load_err_o}, 32'd1);
        check_eq("cks_bad_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
        check_sb_empty("sb_empty_cks_bad");
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the imem write port. Holds the CPU in reset until the image is fully loaded, so the core's instruction fetch only starts once the load is complete. Sits in the SoC between an external byte source (UART/JTAG bridge) and the imem write port.

## Interface
- IMEM_DEPTH, 1024: imem capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- byte_valid_i  in  1  source has a byte.
- byte_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- imem_we_o  out  1  one-cycle write strobe.
- imem_waddr_o  out  32  byte address; always word-aligned.
- imem_wdata_o  out  32  write data.
- cpu_rst_n_o  out  1  active-low reset to cpu_top; low until DONE.
- load_done_o  out  1  image loaded; sticky until rst_n.
- load_err_o  out  1  image rejected; sticky until rst_n.

## Operation
- Stream format: a 4-byte header N (word count, LSB first), then N words, each sent LSB first.
- A byte is transferred when byte_valid_i && byte_ready_o at the rising edge.
- FSM states: HDR, DATA, WRITE, DONE, ERR. Reset state is HDR.
- HDR:
  - Collect 4 bytes into the header word.
  - If N == 0, go to DONE.
  - If N > IMEM_DEPTH, go to ERR.
  - Otherwise go to DATA; word counter = 0.
- DATA:
  - Collect 4 bytes. Byte k (0..3) goes to bits [8k+7:8k].
  - On the 4th byte, go to WRITE.
- WRITE (one cycle):
  - imem_we_o = 1.
  - imem_waddr_o = BASE_ADDR + 4*word_cnt.
  - imem_wdata_o = the assembled word.
  - Increment word_cnt. Go to DONE if word_cnt+1 == N, else DATA.
- DONE: load_done_o = 1 and cpu_rst_n_o = 1. byte_ready_o = 0; further bytes are ignored.
- ERR: load_err_o = 1, cpu_rst_n_o stays 0, byte_ready_o = 0.
- Counter widths:
  - Byte index: 2 bits, wraps 3→0.
  - word_cnt: 32 bits; compared against N, never wraps because N ≤ IMEM_DEPTH.
- Address arithmetic is modulo 2^32.

## Timing
- Reset values of all outputs are 0: byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o, cpu_rst_n_o, load_done_o, load_err_o. byte_ready_o rises on the first clock edge after reset deasserts.
- byte_ready_o = 1 in HDR and DATA, 0 in WRITE, DONE and ERR. It is registered from the next state.
- Latency: imem_we_o pulses in the cycle immediately after the 4th byte of a word is accepted.
- Maximum throughput: 4 bytes per 5 cycles.
- imem_waddr_o and imem_wdata_o hold their last values outside WRITE.
- cpu_rst_n_o and load_done_o rise together in the cycle the FSM enters DONE. For N ≠ 0, that is the cycle after the last WRITE.
- Reset asserted mid-load aborts immediately:
  - All outputs go to their reset values.
  - Partial bytes are discarded; words already written remain in imem.
  - After reset, loading restarts at HDR.
- byte_valid_i without byte_ready_o: the byte is held by the source (standard valid/ready); the loader never drops a byte.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the N data words, the stream carries one more 4-byte trailer word.
  - The loader keeps a running 32-bit sum, modulo 2^32, of all N data words.
  - The trailer is not written to imem.
  - Trailer equal to the sum: go to DONE. Trailer different: go to ERR.
  - For N == 0, the trailer is still expected and must equal 0.
- IMEM_LOADER_CHECKSUM_EN undefined: no trailer; the loader goes to DONE directly after the last WRITE. This is the behaviour described above.

## Structure
- The shared package holds:
  - the FSM state enum (HDR, DATA, WRITE, DONE, ERR, plus TRL when the checksum is enabled);
  - the localparam WORD_BYTES = 4.
- One sub-module, imem_byte_packer: 2-bit byte index and 32-bit shift/assemble register, with accept, clear and word_ready outputs. The FSM, counters and checksum live in imem_loader.
- At SoC level, cpu_rst_n_o drives the rst_n input of cpu_top. imem must gain a synchronous write port (imem_we_o, imem_waddr_o, imem_wdata_o).

## Test plan
- N=2, words 0x00000013 and 0xDEADBEEF streamed back-to-back → two WRITEs: addr 0x0 data 0x00000013, then addr 0x4 data 0xDEADBEEF. Then cpu_rst_n_o=1 and load_done_o=1, exactly one cycle after the second WRITE.
- Header N=0 → DONE right after the 4th header byte, with no imem_we_o pulse. With the checksum enabled, a trailer of 0 gives DONE and a trailer of 1 gives ERR.
- Header N=IMEM_DEPTH+1 → ERR, load_err_o=1, cpu_rst_n_o stays 0, byte_ready_o=0.
- Random gaps in byte_valid_i during N=3 → data and addresses identical to the gap-free run; no byte accepted while byte_ready_o=0 in WRITE.
- rst_n pulsed low after 2 bytes of word 1 → all outputs go to reset values asynchronously. A fresh N=1 stream then writes addr BASE_ADDR correctly.
- With IMEM_LOADER_CHECKSUM_EN and N=2, words 0xFFFFFFFF and 0x00000002 → a trailer of 0x00000001 gives DONE; a trailer of 0x00000002 gives ERR with both words already written.
